// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants for the MMIO I/O controller: register offsets inside the
// 16-byte window, TMR_CTRL bit positions and INT_PEND bit positions.
package mmio_io_ctrl_pkg;

    localparam logic [3:0] OFS_GPIO_OUT  = 4'h0;  // banks at 0x0..0x3
    localparam logic [3:0] OFS_GPIO_IN   = 4'h4;  // banks at 0x4..0x7
    localparam logic [3:0] OFS_INT_PEND  = 4'h8;
    localparam logic [3:0] OFS_INT_MASK  = 4'h9;
    localparam logic [3:0] OFS_INT_VEC   = 4'hA;
    localparam logic [3:0] OFS_TMR_CTRL  = 4'hB;
    localparam logic [3:0] OFS_TMR_PRESC = 4'hC;
    localparam logic [3:0] OFS_TMR_CMP   = 4'hD;
    localparam logic [3:0] OFS_TMR_CNT   = 4'hE;
    localparam logic [3:0] OFS_STATUS    = 4'hF;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;

    localparam int unsigned PEND_TMR_BIT  = 0;
    localparam int unsigned PEND_GPIO_BIT = 1;  // bank k uses bit PEND_GPIO_BIT + k

    // Window is 16-aligned, so only the upper nibble decides a hit.
    function automatic logic in_window(logic [7:0] addr, logic [7:0] base);
        return addr[7:4] == base[7:4];
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU data-memory port as seen by the MMIO window.
interface mmio_io_ctrl_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic       hit;
    logic [7:0] r_data;

    modport master (output addr, output w_data, output w_en, input hit, input r_data);
    modport slave  (input addr, input w_data, input w_en, output hit, output r_data);
endinterface

// File: rtl/mmio_io_ctrl_timer.sv
// Prescaled compare timer: prescaler, counter, compare match and the
// one-shot enable clear. Enable/reload/prescale/compare live in the parent.
module mmio_io_ctrl_timer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       auto_reload_i,
    input  logic [7:0] presc_i,
    input  logic [7:0] cmp_i,
    output logic [7:0] cnt_o,
    output logic       match_o,
    output logic       en_clr_o
);
    logic [7:0] pcnt_q, pcnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tick;

    assign tick     = en_i && (pcnt_q == presc_i);
    assign match_o  = tick && (cnt_q == cmp_i);
    assign en_clr_o = match_o && !auto_reload_i;
    assign cnt_o    = cnt_q;

    // Next prescaler/counter; disabled timer parks both at zero so a later
    // enable always starts a full period.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        if (!en_i) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = (cnt_q == cmp_i) ? 8'h00 : cnt_q + 8'h01;
        end else begin
            pcnt_d = pcnt_q + 8'h01;
        end
    end

    // Timer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Relocatable 16-byte MMIO window: GPIO banks, compare timer and a masked,
// pending-latched interrupt. Define MMIO_IO_GPIO_IRQ_EN to add per-bank
// input change detection feeding INT_PEND[1+k].
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned GPIO_CH     = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mmio_io_ctrl_if.slave          bus,
    output logic [8*GPIO_CH-1:0]   gpio_out_o,
    input  logic [8*GPIO_CH-1:0]   gpio_in_i,
    output logic                   int_req_o,
    output logic [7:0]             int_vec_o
);
    localparam int unsigned NB      = 8 * GPIO_CH;
    localparam logic [2:0]  GpioChW = 3'(GPIO_CH);
`ifdef MMIO_IO_GPIO_IRQ_EN
    localparam logic [7:0]  PendValid = 8'((1 << (GPIO_CH + 1)) - 1);
`else
    localparam logic [7:0]  PendValid = 8'h01;
`endif

    logic          hit, wr;
    logic [3:0]    ofs;
    logic [7:0]    rd;

    logic [NB-1:0] gpio_out_q, gpio_out_d;
    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] gpio_in_s;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    vec_q, vec_d;
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic [7:0]    presc_q, presc_d;
    logic [7:0]    cmp_q, cmp_d;
    logic          int_req_q;
    logic [7:0]    hw_set;

    logic [7:0]    tmr_cnt;
    logic          tmr_match, tmr_en_clr;

    assign hit        = in_window(bus.addr, BASE_ADDR);
    assign ofs        = bus.addr[3:0];
    assign wr         = bus.w_en && hit;
    assign gpio_in_s  = sync_q[SYNC_STAGES-1];
    assign gpio_out_o = gpio_out_q;
    assign int_req_o  = int_req_q;
    assign int_vec_o  = vec_q;
    assign bus.hit    = hit;
    assign bus.r_data = rd;

    mmio_io_ctrl_timer u_timer (
        .clock         (clock),
        .reset_n       (reset_n),
        .en_i          (en_q),
        .auto_reload_i (auto_q),
        .presc_i       (presc_q),
        .cmp_i         (cmp_q),
        .cnt_o         (tmr_cnt),
        .match_o       (tmr_match),
        .en_clr_o      (tmr_en_clr)
    );

    // Pad input synchroniser chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef MMIO_IO_GPIO_IRQ_EN
    logic [NB-1:0] gpio_prev_q;

    // Previous synchronised value, for per-bank change detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) gpio_prev_q <= '0;
        else          gpio_prev_q <= gpio_in_s;
    end

    // Hardware pend sources: timer match plus any bank whose input changed.
    always_comb begin
        hw_set = '0;
        hw_set[PEND_TMR_BIT] = tmr_match;
        for (int unsigned k = 0; k < GPIO_CH; k++) begin
            hw_set[PEND_GPIO_BIT + k] = |(gpio_in_s[8*k +: 8] ^ gpio_prev_q[8*k +: 8]);
        end
    end
`else
    // Hardware pend sources: timer match only.
    always_comb begin
        hw_set = '0;
        hw_set[PEND_TMR_BIT] = tmr_match;
    end
`endif

    // Register next-state: CPU writes, then hardware pend set so that an event
    // coinciding with a W1C is never lost. A CPU write to TMR_CTRL overrides
    // the one-shot enable clear.
    always_comb begin
        gpio_out_d = gpio_out_q;
        pend_d     = pend_q;
        mask_d     = mask_q;
        vec_d      = vec_q;
        en_d       = en_q;
        auto_d     = auto_q;
        presc_d    = presc_q;
        cmp_d      = cmp_q;
        if (tmr_en_clr) en_d = 1'b0;
        if (wr) begin
            for (int unsigned k = 0; k < GPIO_CH; k++) begin
                if (ofs == OFS_GPIO_OUT + 4'(k)) gpio_out_d[8*k +: 8] = bus.w_data;
            end
            case (ofs)
                OFS_INT_PEND:  pend_d  = pend_q & ~bus.w_data;
                OFS_INT_MASK:  mask_d  = bus.w_data;
                OFS_INT_VEC:   vec_d   = bus.w_data;
                OFS_TMR_CTRL: begin
                    en_d   = bus.w_data[CTRL_EN_BIT];
                    auto_d = bus.w_data[CTRL_AUTO_BIT];
                end
                OFS_TMR_PRESC: presc_d = bus.w_data;
                OFS_TMR_CMP:   cmp_d   = bus.w_data;
                default: ;
            endcase
        end
        pend_d = (pend_d | hw_set) & PendValid;
    end

    // Control/status registers; int_req lags pend/mask by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            vec_q      <= '0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            presc_q    <= '0;
            cmp_q      <= '0;
            int_req_q  <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            vec_q      <= vec_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            presc_q    <= presc_d;
            cmp_q      <= cmp_d;
            int_req_q  <= |(pend_q & mask_q);
        end
    end

    // Read mux; absent banks and misses read zero.
    always_comb begin
        rd = '0;
        case (ofs)
            OFS_INT_PEND:  rd = pend_q;
            OFS_INT_MASK:  rd = mask_q;
            OFS_INT_VEC:   rd = vec_q;
            OFS_TMR_CTRL:  rd = {6'b0, auto_q, en_q};
            OFS_TMR_PRESC: rd = presc_q;
            OFS_TMR_CMP:   rd = cmp_q;
            OFS_TMR_CNT:   rd = tmr_cnt;
            OFS_STATUS:    rd = {GpioChW, 4'b0, int_req_q};
            default: begin
                for (int unsigned k = 0; k < GPIO_CH; k++) begin
                    if (ofs == OFS_GPIO_OUT + 4'(k)) rd = gpio_out_q[8*k +: 8];
                    if (ofs == OFS_GPIO_IN + 4'(k))  rd = gpio_in_s[8*k +: 8];
                end
            end
        endcase
        if (!hit) rd = '0;
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios plus a random
// phase, all compared against a register-level reference model.
module tb_mmio_io_ctrl;
    localparam logic [7:0] BASE = 8'hF0;
    localparam int GCH  = 2;
    localparam int SYNC = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [8*GCH-1:0] gpio_out, gpio_in, gin_next;
    logic int_req;
    logic [7:0] int_vec;

    always #5 clock = ~clock;

    mmio_io_ctrl_if bus ();

    mmio_io_ctrl #(
        .BASE_ADDR   (BASE),
        .GPIO_CH     (GCH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .gpio_out_o (gpio_out),
        .gpio_in_i  (gpio_in),
        .int_req_o  (int_req),
        .int_vec_o  (int_vec)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    logic [7:0] rd_last;
    logic       ireq_last;
    int         ed_last;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]       m_gout [GCH];
    logic [8*GCH-1:0] m_sync [SYNC];
    logic [8*GCH-1:0] m_prev;
    logic [7:0]       m_pend, m_mask, m_vec, m_presc, m_cmp, m_pcnt, m_cnt;
    bit               m_en, m_auto, m_ireq;

    function automatic void m_reset();
        for (int k = 0; k < GCH; k++) m_gout[k] = 8'h00;
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        m_prev = '0;
        m_pend = 0; m_mask = 0; m_vec = 0; m_presc = 0; m_cmp = 0; m_pcnt = 0; m_cnt = 0;
        m_en = 0; m_auto = 0; m_ireq = 0;
    endfunction

    function automatic logic [8*GCH-1:0] m_gout_flat();
        logic [8*GCH-1:0] r;
        for (int k = 0; k < GCH; k++) r[8*k +: 8] = m_gout[k];
        return r;
    endfunction

    function automatic logic [7:0] m_read(logic [7:0] a);
        int o;
        o = int'(a[3:0]);
        if (a[7:4] != BASE[7:4]) return 8'h00;
        if (o < GCH) return m_gout[o];
        if (o >= 4 && o < 4 + GCH) return m_sync[SYNC-1][8*(o-4) +: 8];
        case (o)
            8:  return m_pend;
            9:  return m_mask;
            10: return m_vec;
            11: return {6'b0, m_auto, m_en};
            12: return m_presc;
            13: return m_cmp;
            14: return m_cnt;
            15: return {3'(GCH), 4'b0, m_ireq};
            default: return 8'h00;
        endcase
    endfunction

    // One clock edge of the register map, following the documented rules.
    function automatic void m_step(logic [7:0] a, logic [7:0] w, bit we, logic [8*GCH-1:0] gin);
        bit wr, tick, match;
        int o;
        logic [7:0] n_pend, n_pcnt, n_cnt;
        bit n_en, n_auto, n_ireq;
        wr    = we && (a[7:4] == BASE[7:4]);
        o     = int'(a[3:0]);
        tick  = m_en && (m_pcnt == m_presc);
        match = tick && (m_cnt == m_cmp);
        n_ireq = |(m_pend & m_mask);
        n_pend = m_pend;
        if (wr && o == 8) n_pend = m_pend & ~w;
        if (match) n_pend[0] = 1'b1;
`ifdef MMIO_IO_GPIO_IRQ_EN
        for (int k = 0; k < GCH; k++)
            if (m_sync[SYNC-1][8*k +: 8] != m_prev[8*k +: 8]) n_pend[1+k] = 1'b1;
`endif
        n_pcnt = !m_en ? 8'd0 : (tick ? 8'd0 : m_pcnt + 8'd1);
        n_cnt  = !m_en ? 8'd0 : (!tick ? m_cnt : (match ? 8'd0 : m_cnt + 8'd1));
        n_en   = m_en && !(match && !m_auto);
        n_auto = m_auto;
        if (wr) begin
            if (o < GCH) m_gout[o] = w;
            case (o)
                9:  m_mask  = w;
                10: m_vec   = w;
                11: begin n_en = w[0]; n_auto = w[1]; end
                12: m_presc = w;
                13: m_cmp   = w;
                default: ;
            endcase
        end
        m_prev = m_sync[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = gin;
        m_pend = n_pend; m_pcnt = n_pcnt; m_cnt = n_cnt;
        m_en = n_en; m_auto = n_auto; m_ireq = n_ireq;
    endfunction

    // One bus cycle: drive at negedge, compare everything, advance the model.
    task automatic cycle(logic [7:0] a, logic [7:0] w, bit we);
        @(negedge clock);
        bus.addr = a; bus.w_data = w; bus.w_en = we;
        gpio_in = gin_next;
        #1;
        check_eq("hit", bus.hit, (a[7:4] == BASE[7:4]));
        check_eq("r_data", bus.r_data, m_read(a));
        check_eq("gpio_out", gpio_out, m_gout_flat());
        check_eq("int_req", int_req, m_ireq);
        check_eq("int_vec", int_vec, m_vec);
        rd_last = bus.r_data;
        ireq_last = int_req;
        ed_last = edges;
        @(posedge clock);
        edges++;
        m_step(a, w, we, gpio_in);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_gpio_out", gpio_out, 0);
        check_eq("rst_int_req", int_req, 0);
        check_eq("rst_int_vec", int_vec, 0);
        bus.addr = BASE | 8'h0F; bus.w_en = 1'b0;
        #1;
        check_eq("rst_status", bus.r_data, 8'h40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        bit found;
        bus.addr = 0; bus.w_data = 0; bus.w_en = 0;
        gpio_in = 0; gin_next = 0;
        m_reset();
        #1;
        check_reset_outputs();
        @(posedge clock);
        #2 reset_n = 1'b1;

        // GPIO out bank 1, absent bank, outside window.
        cycle(BASE | 8'h01, 8'hA5, 1);
        cycle(BASE | 8'h01, 8'h00, 0);
        check_eq("gpio_rb", rd_last, 8'hA5);
        check_eq("gpio_pin", gpio_out[15:8], 8'hA5);
        cycle(BASE | 8'h03, 8'h00, 0);
        check_eq("absent_bank", rd_last, 8'h00);
        cycle(BASE - 8'h01, 8'h00, 0);
        check_eq("miss_hit", bus.hit, 0);

        // Interrupt vector.
        cycle(BASE | 8'h0A, 8'h40, 1);
        cycle(BASE | 8'h0A, 8'h00, 0);
        check_eq("int_vec_w", int_vec, 8'h40);

        // One-shot timer: PRESC=3, CMP=4 -> match 20 clocks after enable.
        cycle(BASE | 8'h09, 8'h01, 1);
        cycle(BASE | 8'h0C, 8'h03, 1);
        cycle(BASE | 8'h0D, 8'h04, 1);
        cycle(BASE | 8'h0B, 8'h01, 1);
        t0 = edges;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(BASE | 8'h08, 8'h00, 0);
            found = rd_last[0];
        end
        check_eq("oneshot_found", found, 1);
        check_eq("oneshot_period", ed_last - t0, 20);
        check_eq("irq_lag", ireq_last, 0);
        cycle(BASE | 8'h0B, 8'h00, 0);
        check_eq("en_autoclr", rd_last, 8'h00);
        check_eq("irq_set", ireq_last, 1);
        cycle(BASE | 8'h0E, 8'h00, 0);
        check_eq("cnt_idle", rd_last, 8'h00);
        cycle(BASE | 8'h08, 8'h01, 1);
        cycle(BASE | 8'h08, 8'h00, 0);
        check_eq("w1c_pend", rd_last, 8'h00);
        cycle(BASE | 8'h0F, 8'h00, 0);
        check_eq("w1c_irq", ireq_last, 0);

        // Auto-reload: consecutive matches 20 clocks apart.
        cycle(BASE | 8'h0B, 8'h03, 1);
        t0 = edges;
        for (int rep = 0; rep < 2; rep++) begin
            found = 0;
            for (int i = 0; i < 100 && !found; i++) begin
                cycle(BASE | 8'h08, 8'h00, 0);
                found = rd_last[0];
            end
            check_eq("auto_found", found, 1);
            check_eq("auto_period", ed_last - t0, 20 * (rep + 1));
            cycle(BASE | 8'h08, 8'h01, 1);
        end

        // W1C landing on the match edge must not lose the event.
        n = 0;
        while (!(m_en && m_pcnt == m_presc && m_cnt == m_cmp) && n < 100) begin
            cycle(BASE | 8'h08, 8'h00, 0);
            n++;
        end
        cycle(BASE | 8'h08, 8'h01, 1);
        cycle(BASE | 8'h08, 8'h00, 0);
        check_eq("w1c_vs_set", rd_last[0], 1);
        cycle(BASE | 8'h0B, 8'h00, 1);
        cycle(BASE | 8'h08, 8'h01, 1);

        // Write to read-only TMR_CNT is ignored.
        cycle(BASE | 8'h0E, 8'h55, 1);
        cycle(BASE | 8'h0E, 8'h00, 0);
        check_eq("cnt_ro", rd_last, 8'h00);

        // GPIO input synchroniser and change detect.
        gin_next = 16'h0008;
        cycle(BASE | 8'h04, 8'h00, 0);
        cycle(BASE | 8'h04, 8'h00, 0);
        check_eq("sync_1clk", rd_last, 8'h00);
        cycle(BASE | 8'h04, 8'h00, 0);
        check_eq("sync_2clk", rd_last, 8'h08);
        cycle(BASE | 8'h08, 8'h00, 0);
`ifdef MMIO_IO_GPIO_IRQ_EN
        check_eq("gpio_pend", rd_last, 8'h02);
`else
        check_eq("gpio_pend", rd_last, 8'h00);
`endif
        cycle(BASE | 8'h08, 8'hFF, 1);

        // Asynchronous reset in the middle of an auto-reload run.
        cycle(BASE | 8'h09, 8'hFF, 1);
        cycle(BASE | 8'h0C, 8'h00, 1);
        cycle(BASE | 8'h0D, 8'h01, 1);
        cycle(BASE | 8'h0B, 8'h03, 1);
        for (int i = 0; i < 7; i++) cycle(BASE | 8'h0E, 8'h00, 0);
        check_eq("pre_rst_irq", ireq_last, 1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        m_reset();
        #1;
        check_reset_outputs();
        @(posedge clock);
        #2 reset_n = 1'b1;
        cycle(BASE | 8'h0B, 8'h00, 0);
        check_eq("post_rst_ctrl", rd_last, 8'h00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a, w;
            bit we;
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = {BASE[7:4], 4'($urandom)};
            we = ($urandom_range(0, 2) != 0);
            w = 8'($urandom);
            if (a[3:0] == 4'hC || a[3:0] == 4'hD) w = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) gin_next = 16'($urandom);
            cycle(a, w, we);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
